// File: rtl/control.sv
// Main instruction decoder: maps opcode/multiDiv onto the datapath control strobes.
// All strobes are registered, so the decode of an opcode appears one clock later.
module control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       multiDiv,
  output logic       aluBType,
  output logic       aluSrc,
  output logic       signChange,
  output logic       memRead,
  output logic       memToReg,
  output logic       memWrite,
  output logic [1:0] aluControl,
  output logic [1:0] regWrite,
  output logic [1:0] jumpBranch
);

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BGT   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0111;
  localparam logic [3:0] OP_LOAD  = 4'b1010;
  localparam logic [3:0] OP_STORE = 4'b1011;
  localparam logic [3:0] OP_SUBI  = 4'b1100;
  localparam logic [3:0] OP_ADDIU = 4'b1101;
  localparam logic [3:0] OP_TYPEA = 4'b1111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_AND  = 2'b11;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_DEST = 2'b01;
  localparam logic [1:0] RW_PAIR = 2'b10;

  localparam logic [1:0] JB_SEQ = 2'b00;
  localparam logic [1:0] JB_BEQ = 2'b01;
  localparam logic [1:0] JB_BLT = 2'b10;
  localparam logic [1:0] JB_JMP = 2'b11;

  logic       alu_b_type_d,  alu_b_type_q;
  logic       alu_src_d,     alu_src_q;
  logic       sign_change_d, sign_change_q;
  logic       mem_read_d,    mem_read_q;
  logic       mem_to_reg_d,  mem_to_reg_q;
  logic       mem_write_d,   mem_write_q;
  logic [1:0] alu_control_d, alu_control_q;
  logic [1:0] reg_write_d,   reg_write_q;
  logic [1:0] jump_branch_d, jump_branch_q;

  // Unused opcodes fall through to the all-zero NOP word.
  always_comb begin
    alu_b_type_d  = 1'b0;
    alu_src_d     = 1'b0;
    sign_change_d = 1'b0;
    mem_read_d    = 1'b0;
    mem_to_reg_d  = 1'b0;
    mem_write_d   = 1'b0;
    alu_control_d = ALU_ADD;
    reg_write_d   = RW_NONE;
    jump_branch_d = JB_SEQ;
    case (opcode)
      OP_TYPEA: begin
        alu_control_d = ALU_FUNC;
        // multiDiv is only looked at here, so an undriven flag elsewhere cannot leak X.
        reg_write_d   = (multiDiv === 1'b1) ? RW_PAIR : RW_DEST;
      end
      OP_ADDI: begin
        alu_src_d     = 1'b1;
        sign_change_d = 1'b1;
        reg_write_d   = RW_DEST;
      end
      OP_ANDI: begin
        alu_src_d     = 1'b1;
        alu_control_d = ALU_AND;
        reg_write_d   = RW_DEST;
      end
      OP_LOAD: begin
        alu_src_d     = 1'b1;
        sign_change_d = 1'b1;
        mem_read_d    = 1'b1;
        mem_to_reg_d  = 1'b1;
        reg_write_d   = RW_DEST;
      end
      OP_STORE: begin
        alu_src_d     = 1'b1;
        sign_change_d = 1'b1;
        mem_write_d   = 1'b1;
      end
      OP_SUBI: begin
        alu_src_d     = 1'b1;
        sign_change_d = 1'b1;
        alu_control_d = ALU_SUB;
        reg_write_d   = RW_DEST;
      end
      OP_ADDIU: begin
        alu_src_d     = 1'b1;
        reg_write_d   = RW_DEST;
      end
      OP_BEQ: begin
        alu_control_d = ALU_SUB;
        jump_branch_d = JB_BEQ;
      end
      OP_BLT: begin
        alu_control_d = ALU_SUB;
        jump_branch_d = JB_BLT;
      end
      OP_BGT: begin
        // Greater-than reuses the less-than compare with A/B swapped.
        alu_b_type_d  = 1'b1;
        alu_control_d = ALU_SUB;
        jump_branch_d = JB_BLT;
      end
      OP_JMP: begin
        jump_branch_d = JB_JMP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_b_type_q  <= 1'b0;
      alu_src_q     <= 1'b0;
      sign_change_q <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      mem_write_q   <= 1'b0;
      alu_control_q <= 2'b00;
      reg_write_q   <= 2'b00;
      jump_branch_q <= 2'b00;
    end else begin
      alu_b_type_q  <= alu_b_type_d;
      alu_src_q     <= alu_src_d;
      sign_change_q <= sign_change_d;
      mem_read_q    <= mem_read_d;
      mem_to_reg_q  <= mem_to_reg_d;
      mem_write_q   <= mem_write_d;
      alu_control_q <= alu_control_d;
      reg_write_q   <= reg_write_d;
      jump_branch_q <= jump_branch_d;
    end
  end

  assign aluBType   = alu_b_type_q;
  assign aluSrc     = alu_src_q;
  assign signChange = sign_change_q;
  assign memRead    = mem_read_q;
  assign memToReg   = mem_to_reg_q;
  assign memWrite   = mem_write_q;
  assign aluControl = alu_control_q;
  assign regWrite   = reg_write_q;
  assign jumpBranch = jump_branch_q;

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for the instruction decoder: driver queues expected words,
// monitor pops and compares one edge later, plus reset and invariant checks.
module tb_control;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       multiDiv;
  logic       aluBType, aluSrc, signChange, memRead, memToReg, memWrite;
  logic [1:0] aluControl, regWrite, jumpBranch;

  control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .multiDiv(multiDiv),
    .aluBType(aluBType), .aluSrc(aluSrc), .signChange(signChange),
    .memRead(memRead), .memToReg(memToReg), .memWrite(memWrite),
    .aluControl(aluControl), .regWrite(regWrite), .jumpBranch(jumpBranch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word layout: bt src sgn mr m2r mw alu[1:0] rw[1:0] jb[1:0]
  typedef logic [11:0] word_t;

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];
  word_t cur_exp;
  bit    cur_valid = 0;
  bit    run_done = 0;

  function automatic word_t pack(bit bt, bit src, bit sgn, bit mr, bit m2r, bit mw,
                                 int alu, int rw, int jb);
    word_t w;
    w = {bt, src, sgn, mr, m2r, mw, 2'(alu), 2'(rw), 2'(jb)};
    return w;
  endfunction

  // Reference: classify the instruction, then derive each field from its class.
  function automatic word_t model(logic [3:0] op, logic md);
    bit is_imm, is_mem_ld, is_mem_st, writes, signed_imm, swap;
    int alu, rw, jb;
    is_imm = 0; is_mem_ld = 0; is_mem_st = 0; writes = 0; signed_imm = 0; swap = 0;
    alu = 0; rw = 0; jb = 0;
    case (int'(op))
      15: begin alu = 2; rw = (md === 1'b1) ? 2 : 1; end
      1:  begin is_imm = 1; signed_imm = 1; writes = 1; alu = 0; end
      2:  begin is_imm = 1; writes = 1; alu = 3; end
      10: begin is_imm = 1; signed_imm = 1; is_mem_ld = 1; writes = 1; end
      11: begin is_imm = 1; signed_imm = 1; is_mem_st = 1; end
      12: begin is_imm = 1; signed_imm = 1; writes = 1; alu = 1; end
      13: begin is_imm = 1; writes = 1; end
      4:  begin alu = 1; jb = 1; end
      5:  begin alu = 1; jb = 2; end
      6:  begin alu = 1; jb = 2; swap = 1; end
      7:  jb = 3;
      default: ;
    endcase
    if (writes) rw = 1;
    return pack(swap, is_imm, signed_imm, is_mem_ld, is_mem_ld, is_mem_st, alu, rw, jb);
  endfunction

  function automatic word_t actual();
    return {aluBType, aluSrc, signChange, memRead, memToReg, memWrite,
            aluControl, regWrite, jumpBranch};
  endfunction

  task automatic check(string name, word_t act, word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(string name, bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: invariant violated, outputs %b at %0t", name, actual(), $time);
    end
  endtask

  task automatic drive(logic [3:0] op, logic md);
    @(negedge clk);
    opcode   = op;
    multiDiv = md;
    exp_q.push_back(model(op, md));
  endtask

  // Monitor: compare after every rising edge.
  initial begin
    word_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("reset_zero", actual(), '0);
        cur_valid = 0;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("decode", actual(), e);
        cur_exp   = e;
        cur_valid = 1;
        check_bit("no_x", !$isunknown(actual()));
        check_bit("rd_wr_exclusive", !(memRead && memWrite));
        check_bit("memtoreg_needs_read", !(memToReg && !memRead));
        check_bit("regwrite_not_11", regWrite != 2'b11);
        check_bit("no_wb_on_store_or_branch",
                  !((memWrite || jumpBranch != 2'b00) && regWrite != 2'b00));
      end
    end
  end

  // Stability: inputs change at negedge, outputs must hold until the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (cur_valid && rst_n) check("stable_between_edges", actual(), cur_exp);
    end
  end

  initial begin
    logic [3:0] sweep[6];
    logic [3:0] nops[5];
    int guard;
    sweep = '{4'b0001, 4'b0010, 4'b1010, 4'b1011, 4'b1100, 4'b1101};
    nops  = '{4'b0000, 4'b0011, 4'b1000, 4'b1001, 4'b1110};

    rst_n = 1'b0;
    opcode = 4'b1010;
    multiDiv = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("reset_held", actual(), '0);

    // release reset together with the first queued LOAD decode
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(pack(0, 1, 1, 1, 1, 0, 0, 1, 0));

    drive(4'b1111, 1'b1);
    drive(4'b1111, 1'b0);
    for (int i = 0; i < 6; i++) drive(sweep[i], 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b0101, 1'b0);
    drive(4'b0110, 1'b0);
    drive(4'b0111, 1'b1);
    for (int i = 0; i < 5; i++) drive(nops[i], 1'b1);
    drive(4'b0001, 1'bx);
    drive(4'b0000, 1'bx);

    // reset asserted mid-cycle while a STORE decode is pending
    drive(4'b1111, 1'b1);
    drive(4'b1011, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    cur_valid = 0;
    #1 check("async_reset", actual(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 4'b0111;
    exp_q.push_back(model(4'b0111, 1'b0));

    for (int i = 0; i < 1000; i++)
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    run_done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control.md
Name: control

Overview:
- Main instruction decoder for the CPU datapath.
- Takes the 4-bit opcode and the multiply/divide flag from the fetched instruction and produces every datapath control strobe: ALU operand and operation selects, memory strobes, register write-back mode and branch/jump select.
- Outputs are registered: one clock of latency, asynchronous active-low reset to the all-zero NOP word.
- Sits between the instruction register and the execute/memory stages.

Parameters:
- none (opcode width fixed at 4)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  4  instruction opcode field
- multiDiv  input  1  type-A sub-flag: 1 = multiply/divide (two-register result)
- aluBType  output  1  1 = swap ALU A/B operands
- aluSrc  output  1  0 = ALU B from register, 1 = from extended immediate
- signChange  output  1  immediate extension: 1 = sign-extend, 0 = zero-extend
- memRead  output  1  data memory read strobe
- memToReg  output  1  write-back source: 1 = memory, 0 = ALU
- memWrite  output  1  data memory write strobe
- aluControl  output  2  00 ADD, 01 SUB, 10 function-field decoded, 11 AND
- regWrite  output  2  00 none, 01 write destination reg, 10 write result pair (mul/div), 11 never driven
- jumpBranch  output  2  00 sequential, 01 branch-if-equal, 10 branch-if-less, 11 unconditional jump

Behaviour:
- rst_n = 0, asynchronous: all outputs 0 immediately, held while low. The first decode appears at the first rising edge after release.
- Each rising clk registers the decode of the current opcode/multiDiv. Outputs change only on clk edges; latency is 1 cycle.
- Decode table. Fields are aluBType, aluSrc, signChange, memRead, memToReg, memWrite, aluControl, regWrite, jumpBranch; unlisted fields are 0.
  - 1111 type A reg-reg: aluControl=10; regWrite=10 if multiDiv=1, else 01.
  - 0001 ADDI: aluSrc=1, signChange=1, aluControl=00, regWrite=01.
  - 0010 ANDI: aluSrc=1, signChange=0, aluControl=11, regWrite=01.
  - 1010 LOAD: aluSrc=1, signChange=1, memRead=1, memToReg=1, aluControl=00, regWrite=01.
  - 1011 STORE: aluSrc=1, signChange=1, memWrite=1, aluControl=00, regWrite=00.
  - 1100 SUBI: aluSrc=1, signChange=1, aluControl=01, regWrite=01.
  - 1101 ADDIU: aluSrc=1, signChange=0, aluControl=00, regWrite=01.
  - 0100 BEQ: aluControl=01, jumpBranch=01.
  - 0101 BLT: aluControl=01, jumpBranch=10.
  - 0110 BGT: aluBType=1, aluControl=01, jumpBranch=10 (BLT with operands swapped).
  - 0111 JMP: jumpBranch=11; no register or memory activity.
  - 0000 NOP/HALT: all outputs 0.
  - Unused opcodes 0011, 1000, 1001, 1110: decode as NOP (all 0).
- multiDiv affects only opcode 1111. For any other opcode it is ignored, including X/Z values; outputs must not go X.
- Invariants, every cycle:
  - memRead and memWrite are never both 1.
  - memToReg=1 only together with memRead=1.
  - regWrite is never 11.
  - regWrite=00 whenever memWrite=1 or jumpBranch!=00.
- Reset mid-operation: outputs go to 0 asynchronously and the in-flight decode is discarded.

Test Plan:
- Reset: rst_n=0 with opcode=1010 held and clk toggling -> all outputs 0; release rst_n -> next edge gives memRead=1, memToReg=1, aluSrc=1, signChange=1, regWrite=01.
- Type A: opcode=1111, multiDiv=1 -> aluControl=10, regWrite=10, other fields 0. Then multiDiv=0 -> regWrite=01 one edge later.
- Immediates and memory: sweep 0001, 0010, 1010, 1011, 1100, 1101 -> exactly the table values, checked one cycle after each change. 1011 gives memWrite=1, regWrite=00.
- Branch/jump: 0100 -> jumpBranch=01, aluControl=01; 0101 -> 10/01; 0110 -> 10/01 with aluBType=1; 0111 -> jumpBranch=11, aluControl=00.
- NOP/illegal: 0000, 0011, 1000, 1001, 1110 with multiDiv=1 -> all outputs 0. multiDiv=X with opcode 0001 -> no X on any output.
- Latency/invariants: change opcode between edges -> outputs stable until the next rising edge. Random opcodes for 1000 cycles -> all invariants hold.
